// File: rtl/gpu_pixbuf_pkg.sv
// Shared definitions for the pixel write buffer: FSM states, line geometry,
// primitive-end spike code and the 4x4 ordered-dither matrix.
package gpu_pixbuf_pkg;

    localparam int LINE_PIX = 16;
    localparam int ADR_W    = 15;

    localparam logic [1:0] END_PRIM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } pixbuf_state_e;

    // Signed 4-bit entries, entry {Y[1:0],X[1:0]} at bits [idx*4 +: 4], 8-bit colour domain
    localparam logic [63:0] DITHER_MATRIX = 64'hE2F3_0C1D_F3E2_1D0C;

    function automatic logic signed [4:0] dither_offset(input logic [3:0] idx);
        logic [3:0] raw;
        raw = DITHER_MATRIX[idx*4 +: 4];
        return $signed({raw[3], raw});
    endfunction

    function automatic logic [7:0] clamp_c8(input logic [8:0] c);
        return c[8] ? 8'hFF : c[7:0];
    endfunction

endpackage

// File: rtl/gpu_pixel_modulate.sv
// Combinational colour modulation and mask-bit rule for one pixel.
// Optional ordered dither is enabled with `define GPU_PIXBUF_DITHER_EN.
module gpu_pixel_modulate
    import gpu_pixbuf_pkg::*;
(
    input  logic        tex_disable,
    input  logic        force_mask,
    input  logic [1:0]  scr_x,
    input  logic [1:0]  scr_y,
    input  logic [15:0] texel,
    input  logic [8:0]  r,
    input  logic [8:0]  g,
    input  logic [8:0]  b,
    output logic [15:0] pixel
);

`ifdef GPU_PIXBUF_DITHER_EN
    // Textured products are brought to the 8-bit domain (>>4) so dither and the
    // 0..255 clamp apply identically to both paths before the final >>3.
    function automatic logic [4:0] mod_chan(input logic [4:0] t5, input logic [8:0] c,
                                            input logic tex, input logic signed [4:0] off);
        logic [7:0]         c8;
        logic [12:0]        prod;
        logic signed [10:0] v;
        c8   = clamp_c8(c);
        prod = {8'd0, t5} * {5'd0, c8};
        v    = tex ? $signed(11'(prod >> 4)) : $signed({3'b000, c8});
        v    = v + {{6{off[4]}}, off};
        if (v < 11'sd0)
            v = 11'sd0;
        else if (v > 11'sd255)
            v = 11'sd255;
        return v[7:3];
    endfunction

    logic signed [4:0] off;
    assign off = dither_offset({scr_y, scr_x});

    always_comb begin
        pixel[4:0]   = mod_chan(texel[4:0],   r, !tex_disable, off);
        pixel[9:5]   = mod_chan(texel[9:5],   g, !tex_disable, off);
        pixel[14:10] = mod_chan(texel[14:10], b, !tex_disable, off);
        pixel[15]    = (!tex_disable && texel[15]) || force_mask;
    end
`else
    function automatic logic [4:0] mod_chan(input logic [4:0] t5, input logic [8:0] c,
                                            input logic tex);
        logic [7:0]  c8;
        logic [12:0] prod;
        logic [12:0] q;
        c8   = clamp_c8(c);
        prod = {8'd0, t5} * {5'd0, c8};
        q    = prod >> 7;
        if (!tex)
            return c8[7:3];
        return (q > 13'd31) ? 5'd31 : 5'(q);
    endfunction

    logic unused_dither;
    assign unused_dither = ^{scr_x, scr_y};

    always_comb begin
        pixel[4:0]   = mod_chan(texel[4:0],   r, !tex_disable);
        pixel[9:5]   = mod_chan(texel[9:5],   g, !tex_disable);
        pixel[14:10] = mod_chan(texel[14:10], b, !tex_disable);
        pixel[15]    = (!tex_disable && texel[15]) || force_mask;
    end
`endif

endmodule

// File: rtl/gpu_pixel_write_buffer.sv
// Packs modulated pixels into a 16-pixel VRAM line and issues masked line writes.
// Build option: GPU_PIXBUF_DITHER_EN (ordered dither inside gpu_pixel_modulate).
module gpu_pixel_write_buffer
    import gpu_pixbuf_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_nrst,
    input  logic                  GPU_TEX_DISABLE,
    input  logic                  GPU_REG_ForcePixel15MaskSet,
    input  logic                  iValidPixel,
    input  logic [1:0]            iPixelStateSpike,
    input  logic [9:0]            iScrX,
    input  logic [8:0]            iScrY,
    input  logic [15:0]           iTexel,
    input  logic                  iTransparent,
    input  logic [8:0]            iR,
    input  logic [8:0]            iG,
    input  logic [8:0]            iB,
    output logic                  oPause,
    output logic                  oWriteRequ,
    output logic [ADR_W-1:0]      oWriteAdr,
    output logic [LINE_PIX*16-1:0] oWriteData,
    output logic [LINE_PIX-1:0]   oWriteMask,
    input  logic                  iWriteAck,
    output logic                  oBufferEmpty
);

    pixbuf_state_e          state_q, state_d;
    logic [ADR_W-1:0]       tag_q, tag_d;
    logic                   tag_valid_q, tag_valid_d;
    logic [LINE_PIX-1:0]    mask_q, mask_d;
    logic [LINE_PIX*16-1:0] data_q, data_d;

    logic [15:0]            pixel;
    logic [ADR_W-1:0]       pix_tag;
    logic [LINE_PIX-1:0]    slot_bit;
    logic                   tag_hit;
    logic                   opaque;
    logic                   end_prim;
    logic                   pause;

    gpu_pixel_modulate u_modulate (
        .tex_disable (GPU_TEX_DISABLE),
        .force_mask  (GPU_REG_ForcePixel15MaskSet),
        .scr_x       (iScrX[1:0]),
        .scr_y       (iScrY[1:0]),
        .texel       (iTexel),
        .r           (iR),
        .g           (iG),
        .b           (iB),
        .pixel       (pixel)
    );

    assign pix_tag  = {iScrY, iScrX[9:4]};
    assign slot_bit = LINE_PIX'(1) << iScrX[3:0];
    assign tag_hit  = tag_valid_q && (tag_q == pix_tag);
    assign opaque   = iValidPixel && !iTransparent;
    assign end_prim = iValidPixel && (iPixelStateSpike == END_PRIM);

    // A mismatching opaque pixel in ACCUM stalls in the same cycle; it is
    // re-presented by upstream and lands in the new line after the ack.
    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        tag_valid_d = tag_valid_q;
        mask_d      = mask_q;
        data_d      = data_q;
        pause       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (opaque) begin
                    data_d[iScrX[3:0]*16 +: 16] = pixel;
                    tag_d       = pix_tag;
                    tag_valid_d = 1'b1;
                    mask_d      = slot_bit;
                    state_d     = end_prim ? ST_FLUSH : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (opaque && !tag_hit) begin
                    pause   = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
                    if (opaque) begin
                        data_d[iScrX[3:0]*16 +: 16] = pixel;
                        mask_d = mask_q | slot_bit;
                    end
                    if ((mask_d == {LINE_PIX{1'b1}}) || end_prim)
                        state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                pause = 1'b1;
                if (iWriteAck) begin
                    mask_d      = '0;
                    tag_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= ST_IDLE;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            mask_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
        end
    end

    assign oPause       = pause;
    assign oWriteRequ   = (state_q == ST_FLUSH);
    assign oWriteAdr    = tag_q;
    assign oWriteData   = data_q;
    assign oWriteMask   = mask_q;
    assign oBufferEmpty = (state_q == ST_IDLE);

endmodule

// File: tb/tb_gpu_pixel_write_buffer.sv
// Directed bench for gpu_pixel_write_buffer: table of single-pixel flushes plus
// hand sequences for full-line, tag-miss stall, transparency and reset mid-flush.
module tb_gpu_pixel_write_buffer;

    logic         clk;
    logic         i_nrst;
    logic         GPU_TEX_DISABLE;
    logic         GPU_REG_ForcePixel15MaskSet;
    logic         iValidPixel;
    logic [1:0]   iPixelStateSpike;
    logic [9:0]   iScrX;
    logic [8:0]   iScrY;
    logic [15:0]  iTexel;
    logic         iTransparent;
    logic [8:0]   iR, iG, iB;
    logic         oPause;
    logic         oWriteRequ;
    logic [14:0]  oWriteAdr;
    logic [255:0] oWriteData;
    logic [15:0]  oWriteMask;
    logic         iWriteAck;
    logic         oBufferEmpty;

    int checks = 0;
    int errors = 0;

    gpu_pixel_write_buffer dut (
        .clk                         (clk),
        .i_nrst                      (i_nrst),
        .GPU_TEX_DISABLE             (GPU_TEX_DISABLE),
        .GPU_REG_ForcePixel15MaskSet (GPU_REG_ForcePixel15MaskSet),
        .iValidPixel                 (iValidPixel),
        .iPixelStateSpike            (iPixelStateSpike),
        .iScrX                       (iScrX),
        .iScrY                       (iScrY),
        .iTexel                      (iTexel),
        .iTransparent                (iTransparent),
        .iR                          (iR),
        .iG                          (iG),
        .iB                          (iB),
        .oPause                      (oPause),
        .oWriteRequ                  (oWriteRequ),
        .oWriteAdr                   (oWriteAdr),
        .oWriteData                  (oWriteData),
        .oWriteMask                  (oWriteMask),
        .iWriteAck                   (iWriteAck),
        .oBufferEmpty                (oBufferEmpty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tex_dis;
        logic        force_m;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [15:0] texel;
        logic [8:0]  r;
        logic [8:0]  g;
        logic [8:0]  b;
        logic [15:0] exp_pix;
        logic [14:0] exp_adr;
        logic [15:0] exp_mask;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] spike, input logic [9:0] x,
                                 input logic [8:0] y, input logic [15:0] texel, input logic transp,
                                 input logic [8:0] r, input logic [8:0] g, input logic [8:0] b,
                                 input logic tex_dis, input logic force_m);
        iValidPixel                 = valid;
        iPixelStateSpike            = spike;
        iScrX                       = x;
        iScrY                       = y;
        iTexel                      = texel;
        iTransparent                = transp;
        iR                          = r;
        iG                          = g;
        iB                          = b;
        GPU_TEX_DISABLE             = tex_dis;
        GPU_REG_ForcePixel15MaskSet = force_m;
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 2'b00, 10'd0, 9'd0, 16'h0, 1'b0, 9'd0, 9'd0, 9'd0, 1'b1, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseAck();
        iWriteAck = 1'b1;
        tick();
        iWriteAck = 1'b0;
    endtask

    task automatic doReset();
        i_nrst = 1'b0;
        tick();
        tick();
        i_nrst = 1'b1;
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 10'd0,    9'd5,   16'h0000, 9'h0FF, 9'h0FF, 9'h0FF, 16'h7FFF, 15'h0140, 16'h0001};
        vecs[1] = '{1'b0, 1'b0, 10'd3,    9'd0,   16'h801F, 9'h080, 9'h080, 9'h080, 16'h801F, 15'h0000, 16'h0008};
        vecs[2] = '{1'b0, 1'b0, 10'd3,    9'd0,   16'h801F, 9'h100, 9'h080, 9'h080, 16'h801F, 15'h0000, 16'h0008};
        vecs[3] = '{1'b0, 1'b0, 10'd17,   9'd2,   16'h7FFF, 9'h040, 9'h040, 9'h040, 16'h3DEF, 15'h0081, 16'h0002};
        vecs[4] = '{1'b1, 1'b1, 10'd1023, 9'd511, 16'h0000, 9'h1FF, 9'h008, 9'h000, 16'h803F, 15'h7FFF, 16'h8000};
        vecs[5] = '{1'b0, 1'b0, 10'd8,    9'd1,   16'h0421, 9'h0FF, 9'h07F, 9'h100, 16'h0401, 15'h0040, 16'h0100};
        vecs[6] = '{1'b1, 1'b0, 10'd2,    9'd3,   16'hFFFF, 9'h010, 9'h010, 9'h010, 16'h0842, 15'h00C0, 16'h0004};

        iWriteAck = 1'b0;
        idleInputs();
        i_nrst = 1'b1;
        #1;
        i_nrst = 1'b0;
        #1;
        checkOutput("reset_pause", 256'(oPause), 256'(1'b0));
        checkOutput("reset_requ",  256'(oWriteRequ), 256'(1'b0));
        checkOutput("reset_adr",   256'(oWriteAdr), 256'(15'h0));
        checkOutput("reset_data",  oWriteData, 256'h0);
        checkOutput("reset_mask",  256'(oWriteMask), 256'(16'h0));
        checkOutput("reset_empty", 256'(oBufferEmpty), 256'(1'b1));
        tick();
        tick();
        i_nrst = 1'b1;
        #1;

        // single pixel + end spike: IDLE goes straight to FLUSH, ack in first request cycle
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 2'b10, vecs[i].x, vecs[i].y, vecs[i].texel, 1'b0,
                          vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].tex_dis, vecs[i].force_m);
            checkOutput($sformatf("vec%0d_pause", i), 256'(oPause), 256'(1'b0));
            tick();
            idleInputs();
            checkOutput($sformatf("vec%0d_requ", i), 256'(oWriteRequ), 256'(1'b1));
            checkOutput($sformatf("vec%0d_adr", i), 256'(oWriteAdr), 256'(vecs[i].exp_adr));
            checkOutput($sformatf("vec%0d_mask", i), 256'(oWriteMask), 256'(vecs[i].exp_mask));
            checkOutput($sformatf("vec%0d_pix", i),
                        256'(oWriteData[16*int'(vecs[i].x[3:0]) +: 16]), 256'(vecs[i].exp_pix));
            pulseAck();
            checkOutput($sformatf("vec%0d_empty", i), 256'(oBufferEmpty), 256'(1'b1));
        end

        // full line of untextured white pixels flushes on the 16th accept
        for (int x = 0; x < 16; x++) begin
            applyStimulus(1'b1, 2'b00, 10'(x), 9'd5, 16'h0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 1'b1, 1'b0);
            checkOutput($sformatf("line_pause%0d", x), 256'(oPause), 256'(1'b0));
            tick();
        end
        idleInputs();
        checkOutput("line_requ", 256'(oWriteRequ), 256'(1'b1));
        checkOutput("line_adr",  256'(oWriteAdr), 256'(15'h0140));
        checkOutput("line_mask", 256'(oWriteMask), 256'(16'hFFFF));
        checkOutput("line_data", oWriteData, {16{16'h7FFF}});
        pulseAck();
        checkOutput("line_empty", 256'(oBufferEmpty), 256'(1'b1));

        // tag miss: stall, delayed ack, then the held pixel starts a new line
        doReset();
        applyStimulus(1'b1, 2'b00, 10'd3, 9'd0, 16'h0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b00, 10'd20, 9'd0, 16'h0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 1'b1, 1'b0);
        checkOutput("miss_pause_same_cycle", 256'(oPause), 256'(1'b1));
        tick();
        for (int c = 0; c < 10; c++) begin
            checkOutput($sformatf("hold%0d_requ", c),  256'(oWriteRequ), 256'(1'b1));
            checkOutput($sformatf("hold%0d_pause", c), 256'(oPause), 256'(1'b1));
            checkOutput($sformatf("hold%0d_adr", c),   256'(oWriteAdr), 256'(15'h0));
            checkOutput($sformatf("hold%0d_mask", c),  256'(oWriteMask), 256'(16'h0008));
            checkOutput($sformatf("hold%0d_data", c),  oWriteData, 256'h7FFF << 48);
            tick();
        end
        pulseAck();
        checkOutput("after_ack_pause", 256'(oPause), 256'(1'b0));
        checkOutput("after_ack_empty", 256'(oBufferEmpty), 256'(1'b1));
        tick();
        idleInputs();
        checkOutput("new_tag_adr",   256'(oWriteAdr), 256'(15'h0001));
        checkOutput("new_tag_mask",  256'(oWriteMask), 256'(16'h0010));
        checkOutput("new_tag_empty", 256'(oBufferEmpty), 256'(1'b0));
        pulseAck();
        checkOutput("stray_ack_empty", 256'(oBufferEmpty), 256'(1'b0));
        checkOutput("stray_ack_mask",  256'(oWriteMask), 256'(16'h0010));
        applyStimulus(1'b1, 2'b10, 10'd21, 9'd0, 16'h0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 1'b1, 1'b0);
        tick();
        idleInputs();
        checkOutput("spike_flush_requ", 256'(oWriteRequ), 256'(1'b1));
        checkOutput("spike_flush_mask", 256'(oWriteMask), 256'(16'h0030));
        checkOutput("spike_flush_adr",  256'(oWriteAdr), 256'(15'h0001));
        pulseAck();

        // transparent-only primitive leaves the buffer untouched
        for (int x = 0; x < 4; x++) begin
            applyStimulus(1'b1, (x == 3) ? 2'b10 : 2'b00, 10'(x), 9'd7, 16'h0, 1'b1,
                          9'h0FF, 9'h0FF, 9'h0FF, 1'b1, 1'b0);
            checkOutput($sformatf("transp%0d_pause", x), 256'(oPause), 256'(1'b0));
            tick();
        end
        idleInputs();
        for (int c = 0; c < 3; c++) begin
            checkOutput($sformatf("transp_requ%0d", c),  256'(oWriteRequ), 256'(1'b0));
            checkOutput($sformatf("transp_empty%0d", c), 256'(oBufferEmpty), 256'(1'b1));
            tick();
        end

        // asynchronous reset while a request is outstanding
        applyStimulus(1'b1, 2'b10, 10'd5, 9'd9, 16'h0, 1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 1'b1, 1'b0);
        tick();
        idleInputs();
        checkOutput("pre_reset_requ", 256'(oWriteRequ), 256'(1'b1));
        #2;
        i_nrst = 1'b0;
        #1;
        checkOutput("async_reset_requ",  256'(oWriteRequ), 256'(1'b0));
        checkOutput("async_reset_empty", 256'(oBufferEmpty), 256'(1'b1));
        checkOutput("async_reset_mask",  256'(oWriteMask), 256'(16'h0));
        tick();
        i_nrst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
